// File: rtl/seq_detect_multi.sv
// Detects PAT_LEN-word pattern repeated back-to-back n times in a valid-qualified
// word stream; runtime-loadable pattern, pulse/sticky flag, saturating count.
module seq_detect_multi #(
  parameter int                          DATA_W   = 8,
  parameter int                          PAT_LEN  = 4,
  parameter int                          N_W      = 2,
  parameter int                          CNT_W    = 8,
  parameter logic [PAT_LEN*DATA_W-1:0]   PAT_INIT = 32'hCCDDEEFF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_W-1:0]           data_in,
  input  logic                        data_valid,
  input  logic [N_W-1:0]              n,
  input  logic                        mode,
  input  logic [PAT_LEN*DATA_W-1:0]   pat_in,
  input  logic                        cfg_load,
  output logic                        data_flag,
  output logic [N_W-1:0]              rep_cnt,
  output logic [CNT_W-1:0]            det_cnt
);

  localparam int                IDX_W    = $clog2(PAT_LEN);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(PAT_LEN - 1);

  logic [PAT_LEN*DATA_W-1:0] pat_q,  pat_d;
  logic [N_W-1:0]            n_q,    n_d;
  logic                      mode_q, mode_d;
  logic [IDX_W-1:0]          idx_q,  idx_d;
  logic [N_W-1:0]            rep_q,  rep_d;
  logic                      flag_q, flag_d;
  logic [CNT_W-1:0]          det_q,  det_d;

  logic [DATA_W-1:0] pat_word [PAT_LEN];
  logic [N_W-1:0]    rep_next;
  logic              hit;

  // Word 0 is the most-significant slice: it is the first word expected on the wire.
  always_comb begin
    for (int i = 0; i < PAT_LEN; i++) begin
      pat_word[i] = pat_q[(PAT_LEN-1-i)*DATA_W +: DATA_W];
    end
  end

  assign rep_next = rep_q + N_W'(1);

  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    pat_d  = pat_q;
    n_d    = n_q;
    mode_d = mode_q;
    idx_d  = idx_q;
    rep_d  = rep_q;
    det_d  = det_q;
    flag_d = 1'b0;
    hit    = 1'b0;

    if (cfg_load) begin
      pat_d  = pat_in;
      n_d    = n;
      mode_d = mode;
      idx_d  = '0;
      rep_d  = '0;
    end else begin
      if (data_valid) begin
        if (data_in == pat_word[idx_q]) begin
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            // n==0 disables detection; rep_cnt then simply wraps.
            if ((n_q != '0) && (rep_next == n_q)) begin
              hit   = 1'b1;
              rep_d = '0;
            end else begin
              rep_d = rep_next;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          rep_d = '0;
          idx_d = (data_in == pat_word[0]) ? IDX_W'(1) : '0;
        end
      end
      flag_d = hit | (mode_q & flag_q);
      if (hit && (det_q != '1)) begin
        det_d = det_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: the pattern is a handful of flops, not a RAM, so it takes a reset value.
      pat_q  <= PAT_INIT;
      n_q    <= '0;
      mode_q <= 1'b0;
      idx_q  <= '0;
      rep_q  <= '0;
      flag_q <= 1'b0;
      det_q  <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of the others.
      pat_q  <= pat_d;
      n_q    <= n_d;
      mode_q <= mode_d;
      idx_q  <= idx_d;
      rep_q  <= rep_d;
      flag_q <= flag_d;
      det_q  <= det_d;
    end
  end

  assign data_flag = flag_q;
  assign rep_cnt   = rep_q;
  assign det_cnt   = det_q;

endmodule
